fnd_scan_rx: RTL and testbench

Receive side of the multiplexed seven-segment display bus driven by the display scanner (segment, decimal point and active-low digit enables). It samples the time-multiplexed lines, waits for each digit slot to settle, and decodes the segment pattern back to a 4-bit digit code. It assembles the six digits into a frame and reports protocol and pattern errors. It is used as an on-chip loopback monitor and as a bench checker for the HMS clock display path.

---
 rtl/fnd_scan_rx.sv | 207 ++++++++++++++++++++
 tb/tb_fnd_scan_rx.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fnd_scan_rx.sv
// fnd_scan_rx
//   Receive side of the multiplexed seven-segment display bus. The time-
//   multiplexed lines are registered twice, each digit slot is sampled once
//   it has held steady for STABLE_CYC cycles, and the segment pattern is
//   decoded back to a 4-bit code. Six digits in order 0..5 make one frame.
//
//   Ports
//     clk          system clock
//     rst_n        asynchronous active-low reset
//     i_seg        segment lines {a,b,c,d,e,f,g}, 1 = lit
//     i_seg_dp     decimal point of the active digit
//     i_seg_enb    digit enables, active-low, bit k = digit k
//     o_digits     last complete frame, digit k at [4k+3:4k]
//     o_dp         decimal points of the last complete frame
//     o_frame_vld  one-cycle pulse when o_digits/o_dp update
//     o_err_pat    one-cycle pulse: undecodable pattern captured
//     o_err_seq    one-cycle pulse: out-of-order digit, multiple enables, timeout
//
//   state   | meaning
//   IDLE    | waiting for a capture of digit 0
//   COLLECT | frame in progress, waiting for digit expected_q

module fnd_scan_rx #(
    parameter int unsigned STABLE_CYC  = 4,
    parameter int unsigned TIMEOUT_CYC = 20000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  i_seg,
    input  logic        i_seg_dp,
    input  logic [5:0]  i_seg_enb,
    output logic [23:0] o_digits,
    output logic [5:0]  o_dp,
    output logic        o_frame_vld,
    output logic        o_err_pat,
    output logic        o_err_seq
);

    localparam logic [7:0]  STB_MAX  = 8'(STABLE_CYC);
    localparam logic [7:0]  STB_FIRE = 8'(STABLE_CYC - 1);
    localparam logic [31:0] TO_LIM   = 32'(TIMEOUT_CYC);
    localparam logic [13:0] IN_RST   = {6'h3F, 8'h00};

    typedef enum logic {IDLE, COLLECT} state_t;

    // {enb[5:0], seg[6:0], dp}
    logic [13:0] r1_q, r2_q;
    logic [7:0]  stab_cnt_q, stab_cnt_d;
    logic        strobe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_q       <= IN_RST;
            r2_q       <= IN_RST;
            stab_cnt_q <= '0;
        end else begin
            r1_q       <= {i_seg_enb, i_seg, i_seg_dp};
            r2_q       <= r1_q;
            stab_cnt_q <= stab_cnt_d;
        end
    end

    always_comb begin
        if (r1_q != r2_q)
            stab_cnt_d = '0;
        else if (stab_cnt_q != STB_MAX)
            stab_cnt_d = stab_cnt_q + 8'd1;
        else
            stab_cnt_d = stab_cnt_q;
    end

    // The counter only steps by one or clears, so it sits at STABLE_CYC-1
    // for exactly one cycle per settled slot.
    assign strobe = (stab_cnt_q == STB_FIRE);

    logic [5:0] enb_act;
    logic       enb_blank, enb_one, enb_multi;
    logic [2:0] slot_k;
    logic [6:0] seg_r;
    logic       dp_r;
    logic [3:0] dec_code;
    logic       dec_bad;

    assign enb_act   = ~r1_q[13:8];
    assign seg_r     = r1_q[7:1];
    assign dp_r      = r1_q[0];
    assign enb_blank = (enb_act == 6'd0);
    assign enb_one   = $onehot(enb_act);
    assign enb_multi = !enb_blank && !enb_one;

    always_comb begin
        slot_k = 3'd0;
        for (int i = 0; i < 6; i++) begin
            if (enb_act[i]) slot_k = 3'(i);
        end
    end

    always_comb begin
        dec_bad = 1'b0;
        case (seg_r)
            7'b1111110: dec_code = 4'h0;
            7'b0110000: dec_code = 4'h1;
            7'b1101101: dec_code = 4'h2;
            7'b1111001: dec_code = 4'h3;
            7'b0110011: dec_code = 4'h4;
            7'b1011011: dec_code = 4'h5;
            7'b1011111: dec_code = 4'h6;
            7'b1110000: dec_code = 4'h7;
            7'b1111111: dec_code = 4'h8;
            7'b1110011: dec_code = 4'h9;
            7'b0000000: dec_code = 4'hA;
            default: begin
                dec_code = 4'hF;
                dec_bad  = 1'b1;
            end
        endcase
    end

    state_t      state_q;
    logic [2:0]  expected_q;
    logic [23:0] shadow_q;
    logic [5:0]  sdp_q;
    logic [31:0] to_cnt_q;
    logic [23:0] digits_q;
    logic [5:0]  dp_q;
    logic        frame_vld_q, err_pat_q, err_seq_q;
    logic        cap;

    assign cap = strobe && enb_one;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            expected_q  <= '0;
            shadow_q    <= 24'hFFFFFF;
            sdp_q       <= '0;
            to_cnt_q    <= '0;
            digits_q    <= 24'hFFFFFF;
            dp_q        <= '0;
            frame_vld_q <= 1'b0;
            err_pat_q   <= 1'b0;
            err_seq_q   <= 1'b0;
        end else begin
            frame_vld_q <= 1'b0;
            err_pat_q   <= cap && dec_bad;
            err_seq_q   <= 1'b0;
            if (state_q == COLLECT) to_cnt_q <= to_cnt_q + 32'd1;

            if (strobe && enb_multi) begin
                err_seq_q <= 1'b1;
                state_q   <= IDLE;
                shadow_q  <= 24'hFFFFFF;
                sdp_q     <= '0;
                to_cnt_q  <= '0;
            end else if (cap) begin
                case (state_q)
                    IDLE: begin
                        // Joining mid-frame: wait silently for digit 0.
                        if (slot_k == 3'd0) begin
                            shadow_q[3:0] <= dec_code;
                            sdp_q[0]      <= dp_r;
                            expected_q    <= 3'd1;
                            to_cnt_q      <= '0;
                            state_q       <= COLLECT;
                        end
                    end
                    COLLECT: begin
                        to_cnt_q <= '0;
                        if (slot_k == expected_q) begin
                            shadow_q[{slot_k, 2'b00} +: 4] <= dec_code;
                            sdp_q[slot_k]                  <= dp_r;
                            if (slot_k == 3'd5) begin
                                digits_q    <= {dec_code, shadow_q[19:0]};
                                dp_q        <= {dp_r, sdp_q[4:0]};
                                frame_vld_q <= 1'b1;
                                state_q     <= IDLE;
                            end else begin
                                expected_q <= expected_q + 3'd1;
                            end
                        end else begin
                            err_seq_q <= 1'b1;
                            if (slot_k == 3'd0) begin
                                shadow_q[3:0] <= dec_code;
                                sdp_q[0]      <= dp_r;
                                expected_q    <= 3'd1;
                            end else begin
                                state_q <= IDLE;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end else if (state_q == COLLECT && (to_cnt_q + 32'd1) == TO_LIM) begin
                err_seq_q <= 1'b1;
                state_q   <= IDLE;
                to_cnt_q  <= '0;
            end
        end
    end

    assign o_digits    = digits_q;
    assign o_dp        = dp_q;
    assign o_frame_vld = frame_vld_q;
    assign o_err_pat   = err_pat_q;
    assign o_err_seq   = err_seq_q;

endmodule

// File: tb/tb_fnd_scan_rx.sv
// Directed bench for fnd_scan_rx (STABLE_CYC=4, TIMEOUT_CYC=100).
// Inputs are driven and outputs sampled on the falling edge.

module tb_fnd_scan_rx;

    logic        clk;
    logic        rst_n;
    logic [6:0]  seg;
    logic        seg_dp;
    logic [5:0]  seg_enb;
    logic [23:0] digits;
    logic [5:0]  dp;
    logic        frame_vld, err_pat, err_seq;

    int n_checks = 0;
    int n_errors = 0;
    int fv_cnt = 0, pat_cnt = 0, seq_cnt = 0;

    fnd_scan_rx #(.STABLE_CYC(4), .TIMEOUT_CYC(100)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_seg       (seg),
        .i_seg_dp    (seg_dp),
        .i_seg_enb   (seg_enb),
        .o_digits    (digits),
        .o_dp        (dp),
        .o_frame_vld (frame_vld),
        .o_err_pat   (err_pat),
        .o_err_seq   (err_seq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count high cycles of each pulse output; a clean pulse adds exactly one.
    always @(negedge clk) begin
        if (rst_n) begin
            fv_cnt  += int'(frame_vld);
            pat_cnt += int'(err_pat);
            seq_cnt += int'(err_seq);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'h0: seg_of = 7'b1111110;
            4'h1: seg_of = 7'b0110000;
            4'h2: seg_of = 7'b1101101;
            4'h3: seg_of = 7'b1111001;
            4'h4: seg_of = 7'b0110011;
            4'h5: seg_of = 7'b1011011;
            4'h6: seg_of = 7'b1011111;
            4'h7: seg_of = 7'b1110000;
            4'h8: seg_of = 7'b1111111;
            4'h9: seg_of = 7'b1110011;
            4'hA: seg_of = 7'b0000000;
            default: seg_of = 7'b1000001;
        endcase
    endfunction

    // Drive one slot from a falling edge. fv_at/es_at give the number of
    // rising edges after the slot start at which frame_vld/err_seq were first
    // seen high (0 = not seen). glitch flips segment g for slot cycle 1 only.
    task automatic drive_slot(input logic [5:0] enb, input logic [6:0] pat, input logic d,
                              input int len, input bit glitch,
                              output int fv_at, output int es_at);
        fv_at = 0;
        es_at = 0;
        seg_enb = enb;
        seg     = pat;
        seg_dp  = d;
        for (int n = 1; n <= len; n++) begin
            @(negedge clk);
            if (glitch && n == 1) seg = pat ^ 7'b0000001;
            if (glitch && n == 2) seg = pat;
            if (frame_vld && fv_at == 0) fv_at = n;
            if (err_seq && es_at == 0) es_at = n;
        end
    endtask

    task automatic digit_slot(input int k, input logic [6:0] pat, input logic d, input int len);
        int fa, ea;
        drive_slot(~(6'd1 << k), pat, d, len, 1'b0, fa, ea);
    endtask

    task automatic blank(input int len);
        int fa, ea;
        drive_slot(6'h3F, 7'd0, 1'b0, len, 1'b0, fa, ea);
    endtask

    task automatic send_frame(input logic [23:0] v, input logic [5:0] d,
                              input int gap, input bit glitch);
        int fa, ea;
        for (int k = 0; k < 6; k++) begin
            drive_slot(~(6'd1 << k), seg_of(v[4*k +: 4]), d[k], 40, glitch, fa, ea);
            if (gap > 0) blank(gap);
        end
    endtask

    int fv0, pat0, seq0, fa, ea;

    initial begin
        rst_n   = 1'b0;
        seg     = 7'd0;
        seg_dp  = 1'b0;
        seg_enb = 6'h3F;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_digits", digits, 24'hFFFFFF);
        check_eq("rst_dp", dp, 6'd0);
        check_eq("rst_fv", frame_vld, 0);
        check_eq("rst_err_pat", err_pat, 0);
        check_eq("rst_err_seq", err_seq, 0);
        blank(10);

        // 1: clean frame 1,2,3,4,5,9 with latency on digit 5
        fv0 = fv_cnt; pat0 = pat_cnt; seq0 = seq_cnt;
        digit_slot(0, seg_of(4'h1), 1'b0, 40);
        digit_slot(1, seg_of(4'h2), 1'b0, 40);
        digit_slot(2, seg_of(4'h3), 1'b1, 40);
        digit_slot(3, seg_of(4'h4), 1'b0, 40);
        digit_slot(4, seg_of(4'h5), 1'b0, 40);
        drive_slot(6'b011111, seg_of(4'h9), 1'b0, 40, 1'b0, fa, ea);
        check_eq("t1_latency", fa, 6);
        check_eq("t1_digits", digits, 24'h954321);
        check_eq("t1_dp", dp, 6'b000100);
        check_eq("t1_fv_cnt", fv_cnt - fv0, 1);
        check_eq("t1_pat_cnt", pat_cnt - pat0, 0);
        check_eq("t1_seq_cnt", seq_cnt - seq0, 0);

        // 2: undecodable pattern on digit 2
        fv0 = fv_cnt; pat0 = pat_cnt; seq0 = seq_cnt;
        digit_slot(0, seg_of(4'h1), 1'b0, 40);
        digit_slot(1, seg_of(4'h2), 1'b0, 40);
        digit_slot(2, 7'b1000001, 1'b1, 40);
        digit_slot(3, seg_of(4'h4), 1'b0, 40);
        digit_slot(4, seg_of(4'h5), 1'b0, 40);
        digit_slot(5, seg_of(4'h9), 1'b0, 40);
        check_eq("t2_digits", digits, 24'h954F21);
        check_eq("t2_pat_cnt", pat_cnt - pat0, 1);
        check_eq("t2_seq_cnt", seq_cnt - seq0, 0);
        check_eq("t2_fv_cnt", fv_cnt - fv0, 1);

        // 3: order 0,1,3 then a clean frame (digit 2 blank -> A)
        fv0 = fv_cnt; seq0 = seq_cnt;
        digit_slot(0, seg_of(4'h7), 1'b0, 40);
        digit_slot(1, seg_of(4'h7), 1'b0, 40);
        digit_slot(3, seg_of(4'h7), 1'b0, 40);
        blank(20);
        check_eq("t3_seq_cnt", seq_cnt - seq0, 1);
        check_eq("t3_digits_hold", digits, 24'h954F21);
        check_eq("t3_fv_none", fv_cnt - fv0, 0);
        send_frame(24'h870A65, 6'b100001, 0, 1'b0);
        check_eq("t3_digits_new", digits, 24'h870A65);
        check_eq("t3_dp_new", dp, 6'b100001);
        check_eq("t3_seq_after", seq_cnt - seq0, 1);

        // 4: glitch early in each slot, then 2-clk slots
        fv0 = fv_cnt; pat0 = pat_cnt; seq0 = seq_cnt;
        send_frame(24'h123456, 6'b010010, 0, 1'b1);
        check_eq("t4_digits", digits, 24'h123456);
        check_eq("t4_dp", dp, 6'b010010);
        check_eq("t4_fv_cnt", fv_cnt - fv0, 1);
        check_eq("t4_err_cnt", (pat_cnt - pat0) + (seq_cnt - seq0), 0);
        fv0 = fv_cnt; pat0 = pat_cnt; seq0 = seq_cnt;
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < 6; k++) digit_slot(k, seg_of(4'(k)), 1'b0, 2);
        blank(20);
        check_eq("t4_short_fv", fv_cnt - fv0, 0);
        check_eq("t4_short_err", (pat_cnt - pat0) + (seq_cnt - seq0), 0);
        check_eq("t4_short_hold", digits, 24'h123456);

        // 5: two enables active, then a frame with blank gaps
        seq0 = seq_cnt; fv0 = fv_cnt;
        digit_slot(0, seg_of(4'h1), 1'b0, 40);
        drive_slot(6'b111100, seg_of(4'h8), 1'b0, 40, 1'b0, fa, ea);
        check_eq("t5_multi_seq", seq_cnt - seq0, 1);
        digit_slot(1, seg_of(4'h2), 1'b0, 40);
        check_eq("t5_idle_no_seq", seq_cnt - seq0, 1);
        blank(20);
        send_frame(24'h654321, 6'b101010, 20, 1'b0);
        check_eq("t5_digits", digits, 24'h654321);
        check_eq("t5_dp", dp, 6'b101010);
        check_eq("t5_fv_cnt", fv_cnt - fv0, 1);
        check_eq("t5_seq_after", seq_cnt - seq0, 1);

        // 6: timeout after digit 2, then reset mid-frame
        seq0 = seq_cnt; fv0 = fv_cnt;
        digit_slot(0, seg_of(4'h3), 1'b0, 40);
        digit_slot(1, seg_of(4'h3), 1'b0, 40);
        drive_slot(6'b111011, seg_of(4'h3), 1'b0, 150, 1'b0, fa, ea);
        check_eq("t6_timeout_at", ea, 106);
        check_eq("t6_seq_cnt", seq_cnt - seq0, 1);
        check_eq("t6_digits_hold", digits, 24'h654321);
        blank(10);
        digit_slot(0, seg_of(4'h4), 1'b0, 40);
        digit_slot(1, seg_of(4'h4), 1'b0, 20);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("t6_rst_digits", digits, 24'hFFFFFF);
        check_eq("t6_rst_dp", dp, 6'd0);
        rst_n = 1'b1;
        seq0 = seq_cnt; fv0 = fv_cnt;
        for (int k = 1; k < 6; k++) digit_slot(k, seg_of(4'h4), 1'b0, 40);
        check_eq("t6_partial_fv", fv_cnt - fv0, 0);
        check_eq("t6_partial_seq", seq_cnt - seq0, 0);
        check_eq("t6_partial_digits", digits, 24'hFFFFFF);
        blank(10);
        send_frame(24'h987654, 6'b010000, 0, 1'b0);
        check_eq("t6_final_digits", digits, 24'h987654);
        check_eq("t6_final_dp", dp, 6'b010000);
        check_eq("t6_final_fv", fv_cnt - fv0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
